// File: rtl/param_counter_pkg.sv
// ---------------------------------------------------------------------------
// param_counter_pkg
//   Shared types and helpers for the param_counter_bank slice:
//     rd_state_e  - read-port FSM states (IDLE, RESP)
//     mode_e      - counter overflow behaviour (MODE_WRAP, MODE_SATURATE)
//     next_count  - next count value plus hit indication for one increment
// ---------------------------------------------------------------------------
package param_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_e;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } mode_e;

  typedef struct packed {
    logic        hit;
    logic [31:0] value;
  } next_t;

  // Arguments are widened to 33 bits so count + step never overflows for
  // any counter width up to 32.  Saturate mode reports a hit on reaching
  // the limit, so the flag marks the point where the channel stalls.
  function automatic next_t next_count(input logic [32:0] count,
                                       input logic [32:0] step,
                                       input logic [32:0] limit,
                                       input mode_e       mode);
    next_t       r;
    logic [32:0] sum;
    sum     = count + step;
    r.hit   = 1'b0;
    r.value = 32'(sum);
    if (mode == MODE_SATURATE) begin
      if (sum >= limit) begin
        r.hit   = 1'b1;
        r.value = 32'(limit);
      end
    end else if (sum > limit) begin
      r.hit   = 1'b1;
      r.value = 32'(sum - limit - 33'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/param_counter_ch.sv
// ---------------------------------------------------------------------------
// param_counter_ch
//   One counter channel: count register, sticky wrap/saturate flag,
//   increment handshake and synchronous clear.
//   Ports:
//     clk, rst_n  - clock, synchronous active-low reset
//     inc_valid   - increment request
//     inc_ready   - increment accept (low only when saturated at LIMIT)
//     clr         - synchronous clear of count and flag (highest priority)
//     rd_clr      - flag clear from the read port (loses to a flag set)
//     count       - registered count value
//     flag        - sticky hit flag
// ---------------------------------------------------------------------------
module param_counter_ch
  import param_counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] LIMIT    = '1,
  parameter int unsigned      STEP     = 1,
  parameter logic             SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_valid,
  input  logic             clr,
  input  logic             rd_clr,
  output logic             inc_ready,
  output logic [WIDTH-1:0] count,
  output logic             flag
);

  next_t nxt;
  logic  fire;

  assign inc_ready = !(SATURATE && (count == LIMIT));
  assign fire      = inc_valid && inc_ready;
  assign nxt       = next_count(33'(count), 33'(STEP), 33'(LIMIT),
                                SATURATE ? MODE_SATURATE : MODE_WRAP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      flag  <= 1'b0;
    end else begin
      if (fire) begin
        count <= WIDTH'(nxt.value);
      end
      if (fire && nxt.hit) begin
        flag <= 1'b1;
      end else if (rd_clr) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/param_counter_bank.sv
// ---------------------------------------------------------------------------
// param_counter_bank
//   NUM_CH independent event counters with a shared registered read port.
//   Optional feature macro: PARAM_COUNTER_SNAPSHOT_EN - when defined, snap
//   copies all counts into shadow registers and reads return shadow values;
//   when undefined, snap is ignored and reads return live counts.
//   Ports:
//     clk, rst_n              - clock, synchronous active-low reset
//     inc_valid / inc_ready   - per-channel increment handshake
//     clr                     - per-channel synchronous clear
//     flag                    - per-channel sticky wrap/saturate flag
//     rd_req_valid / _ready   - read request handshake, rd_ch selects channel
//     rsp_valid / rsp_ready   - read response handshake
//     rsp_data, rsp_err       - value read, out-of-range indication
//     snap                    - snapshot strobe (optional feature only)
// ---------------------------------------------------------------------------
module param_counter_bank
  import param_counter_pkg::*;
#(
  parameter  int unsigned NUM_CH           = 4,
  parameter  int unsigned WIDTH            = 8,
  parameter  int unsigned LIMIT            = 32'((64'd1 << WIDTH) - 64'd1),
  parameter  int unsigned STEP             = 1,
  parameter  logic        SATURATE         = 1'b0,
  parameter  logic        READ_CLEARS_FLAG = 1'b1,
  localparam int unsigned CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] inc_valid,
  output logic [NUM_CH-1:0] inc_ready,
  input  logic [NUM_CH-1:0] clr,
  output logic [NUM_CH-1:0] flag,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [CH_W-1:0]   rd_ch,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  input  logic              snap
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  rd_state_e         state;
  logic [WIDTH-1:0]  count  [NUM_CH];
  logic [WIDTH-1:0]  rd_src [NUM_CH];
  logic [WIDTH-1:0]  rd_val;
  logic [NUM_CH-1:0] rd_clr;
  logic              rd_accept;
  logic              rd_in_range;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    param_counter_ch #(
      .WIDTH    (WIDTH),
      .LIMIT    (LIM),
      .STEP     (STEP),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_valid (inc_valid[g]),
      .clr       (clr[g]),
      .rd_clr    (rd_clr[g]),
      .inc_ready (inc_ready[g]),
      .count     (count[g]),
      .flag      (flag[g])
    );
  end

`ifdef PARAM_COUNTER_SNAPSHOT_EN
  logic [WIDTH-1:0] shadow [NUM_CH];

  // A read accepted alongside snap samples shadow before this update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '{default: '0};
    end else if (snap) begin
      shadow <= count;
    end
  end

  assign rd_src = shadow;
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign rd_src      = count;
`endif

  assign rd_accept   = (state == IDLE) && rd_req_valid;
  assign rd_in_range = 32'(rd_ch) < NUM_CH;

  always_comb begin
    rd_val = '0;
    rd_clr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(rd_ch) == i) begin
        rd_val    = rd_src[i];
        rd_clr[i] = READ_CLEARS_FLAG && rd_accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      rd_req_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req_valid) begin
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rd_req_ready <= 1'b0;
            rsp_data     <= rd_in_range ? rd_val : '0;
            rsp_err      <= !rd_in_range;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rd_req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_param_counter_bank
//   Directed bench for param_counter_bank using two configurations:
//     dut_w - 3 channels, WIDTH=4, LIMIT=9, STEP=4, wrap mode
//     dut_s - 4 channels, WIDTH=8, LIMIT=5, STEP=1, saturate mode
// ---------------------------------------------------------------------------
module tb_param_counter_bank;

  localparam logic [7:0] W_CFG = 8'h94;
`ifdef PARAM_COUNTER_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0] w_inc_valid, w_inc_ready, w_clr, w_flag;
  logic       w_rd_req_valid, w_rd_req_ready, w_rsp_valid, w_rsp_ready, w_rsp_err, w_snap;
  logic [1:0] w_rd_ch;
  logic [3:0] w_rsp_data;

  logic [3:0] s_inc_valid, s_inc_ready, s_clr, s_flag;
  logic       s_rd_req_valid, s_rd_req_ready, s_rsp_valid, s_rsp_ready, s_rsp_err, s_snap;
  logic [1:0] s_rd_ch;
  logic [7:0] s_rsp_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_counter_bank #(
    .NUM_CH(3), .WIDTH(W_CFG[3:0]), .LIMIT(W_CFG[7:4]), .STEP(W_CFG[3:0]),
    .SATURATE(1'b0), .READ_CLEARS_FLAG(1'b1)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .inc_valid(w_inc_valid), .inc_ready(w_inc_ready),
    .clr(w_clr), .flag(w_flag), .rd_req_valid(w_rd_req_valid),
    .rd_req_ready(w_rd_req_ready), .rd_ch(w_rd_ch), .rsp_valid(w_rsp_valid),
    .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data), .rsp_err(w_rsp_err), .snap(w_snap)
  );

  param_counter_bank #(
    .NUM_CH(4), .WIDTH(8), .LIMIT(5), .STEP(1),
    .SATURATE(1'b1), .READ_CLEARS_FLAG(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .inc_valid(s_inc_valid), .inc_ready(s_inc_ready),
    .clr(s_clr), .flag(s_flag), .rd_req_valid(s_rd_req_valid),
    .rd_req_ready(s_rd_req_ready), .rd_ch(s_rd_ch), .rsp_valid(s_rsp_valid),
    .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .rsp_err(s_rsp_err), .snap(s_snap)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w_read(input logic [1:0] ch, output logic [3:0] data,
                        output logic err, output logic got);
    got = 1'b0; data = '0; err = 1'b0;
    w_rd_ch = ch; w_rd_req_valid = 1'b1;
    tick();
    w_rd_req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (w_rsp_valid) begin
        got = 1'b1; data = w_rsp_data; err = w_rsp_err;
        break;
      end
      tick();
    end
    w_rsp_ready = 1'b1;
    tick();
    w_rsp_ready = 1'b0;
  endtask

  task automatic s_read(input logic [1:0] ch, output logic [7:0] data, output logic got);
    got = 1'b0; data = '0;
    s_rd_ch = ch; s_rd_req_valid = 1'b1;
    tick();
    s_rd_req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (s_rsp_valid) begin
        got = 1'b1; data = s_rsp_data;
        break;
      end
      tick();
    end
    s_rsp_ready = 1'b1;
    tick();
    s_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    w_inc_valid = '0; w_clr = '0; w_rd_req_valid = 1'b0; w_rd_ch = '0; w_rsp_ready = 1'b0; w_snap = 1'b0;
    s_inc_valid = '0; s_clr = '0; s_rd_req_valid = 1'b0; s_rd_ch = '0; s_rsp_ready = 1'b0; s_snap = 1'b0;
    tick(); tick();
    vectors++; if (w_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", w_rsp_valid); end
    vectors++; if (w_rsp_data !== 4'd0) begin miscompares++; $display("FAIL reset_rsp_data: got %0d want 0", w_rsp_data); end
    vectors++; if (w_rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b want 0", w_rsp_err); end
    vectors++; if (w_rd_req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rd_req_ready: got %b want 1", w_rd_req_ready); end
    vectors++; if (w_flag !== 3'b000) begin miscompares++; $display("FAIL reset_flag: got %b want 000", w_flag); end
    vectors++; if (w_inc_ready !== 3'b111) begin miscompares++; $display("FAIL reset_w_inc_ready: got %b want 111", w_inc_ready); end
    vectors++; if (s_inc_ready !== 4'b1111) begin miscompares++; $display("FAIL reset_s_inc_ready: got %b want 1111", s_inc_ready); end
    rst_n = 1'b1;
    tick();
    w_rd_ch = 2'd0; w_rd_req_valid = 1'b1;
    vectors++; if (w_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL lat_before_accept: got %b want 0", w_rsp_valid); end
    tick();
    w_rd_req_valid = 1'b0;
    vectors++; if (w_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL lat_rsp_valid: got %b want 1", w_rsp_valid); end
    vectors++; if (w_rsp_data !== 4'd0 || w_rsp_err !== 1'b0) begin miscompares++; $display("FAIL lat_rsp_data_err: got %0d/%b want 0/0", w_rsp_data, w_rsp_err); end
    vectors++; if (w_rd_req_ready !== 1'b0) begin miscompares++; $display("FAIL lat_rd_req_ready: got %b want 0", w_rd_req_ready); end
    w_rsp_ready = 1'b1;
    tick();
    w_rsp_ready = 1'b0;
    vectors++; if (w_rsp_valid !== 1'b0 || w_rd_req_ready !== 1'b1) begin miscompares++; $display("FAIL lat_return_idle: got valid %b ready %b want 0 1", w_rsp_valid, w_rd_req_ready); end
  endtask

  task automatic test_wrap();
    logic [3:0] d; logic e, g;
    logic [3:0] exp_cnt [3];
    exp_cnt = '{4'd4, 4'd8, 4'd2};
    for (int k = 0; k < 3; k++) begin
      w_inc_valid = 3'b010;
      tick();
      w_inc_valid = 3'b000;
      vectors++; if (w_flag[1] !== (k == 2)) begin miscompares++; $display("FAIL wrap_flag_%0d: got %b want %b", k, w_flag[1], (k == 2)); end
      w_read(2'd1, d, e, g);
      vectors++; if (!g || d !== exp_cnt[k]) begin miscompares++; $display("FAIL wrap_count_%0d: got %0d (rsp %b) want %0d", k, d, g, exp_cnt[k]); end
    end
    vectors++; if (w_flag[1] !== 1'b0) begin miscompares++; $display("FAIL wrap_read_clears_flag: got %b want 0", w_flag[1]); end
    vectors++; if (w_inc_ready !== 3'b111) begin miscompares++; $display("FAIL wrap_inc_ready: got %b want 111", w_inc_ready); end
  endtask

  task automatic test_saturate();
    logic [7:0] d; logic g;
    s_inc_valid = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 4) begin
        vectors++; if (s_inc_ready[2] !== 1'b1) begin miscompares++; $display("FAIL sat_ready_inc4: got %b want 1", s_inc_ready[2]); end
      end
      if (k == 5 || k == 7) begin
        vectors++; if (s_inc_ready[2] !== 1'b0) begin miscompares++; $display("FAIL sat_ready_inc%0d: got %b want 0", k, s_inc_ready[2]); end
      end
    end
    s_inc_valid = 4'b0000;
    s_read(2'd2, d, g);
    vectors++; if (!g || d !== 8'd5) begin miscompares++; $display("FAIL sat_count: got %0d (rsp %b) want 5", d, g); end
    s_clr = 4'b0100;
    tick();
    s_clr = 4'b0000;
    vectors++; if (s_inc_ready[2] !== 1'b1) begin miscompares++; $display("FAIL sat_clr_ready: got %b want 1", s_inc_ready[2]); end
    s_read(2'd2, d, g);
    vectors++; if (!g || d !== 8'd0) begin miscompares++; $display("FAIL sat_clr_count: got %0d (rsp %b) want 0", d, g); end
  endtask

  task automatic test_clr_priority();
    logic [7:0] sd; logic [3:0] wd; logic e, g;
    s_inc_valid = 4'b0001;
    tick(); tick(); tick();
    s_clr = 4'b0001;
    tick();
    s_inc_valid = 4'b0000; s_clr = 4'b0000;
    vectors++; if (s_flag[0] !== 1'b0) begin miscompares++; $display("FAIL clr_s_flag: got %b want 0", s_flag[0]); end
    s_read(2'd0, sd, g);
    vectors++; if (!g || sd !== 8'd0) begin miscompares++; $display("FAIL clr_s_count: got %0d (rsp %b) want 0", sd, g); end
    // ch0 at 8: a coincident increment would wrap and set the flag
    w_inc_valid = 3'b001;
    tick(); tick();
    w_clr = 3'b001;
    tick();
    w_inc_valid = 3'b000; w_clr = 3'b000;
    vectors++; if (w_flag[0] !== 1'b0) begin miscompares++; $display("FAIL clr_w_flag: got %b want 0", w_flag[0]); end
    w_read(2'd0, wd, e, g);
    vectors++; if (!g || wd !== 4'd0) begin miscompares++; $display("FAIL clr_w_count: got %0d (rsp %b) want 0", wd, g); end
  endtask

  task automatic test_flag_vs_read_clear();
    logic [3:0] d; logic e, g;
    w_inc_valid = 3'b010;
    tick();
    w_rd_ch = 2'd1; w_rd_req_valid = 1'b1;
    tick();
    w_inc_valid = 3'b000; w_rd_req_valid = 1'b0;
    vectors++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 4'd6) begin miscompares++; $display("FAIL fvr_pre_inc_data: got %0d (valid %b) want 6", w_rsp_data, w_rsp_valid); end
    vectors++; if (w_flag[1] !== 1'b1) begin miscompares++; $display("FAIL fvr_set_wins: got %b want 1", w_flag[1]); end
    w_rsp_ready = 1'b1;
    tick();
    w_rsp_ready = 1'b0;
    w_read(2'd1, d, e, g);
    vectors++; if (!g || d !== 4'd0) begin miscompares++; $display("FAIL fvr_count: got %0d (rsp %b) want 0", d, g); end
    vectors++; if (w_flag[1] !== 1'b0) begin miscompares++; $display("FAIL fvr_flag_cleared: got %b want 0", w_flag[1]); end
  endtask

  task automatic test_out_of_range();
    w_inc_valid = 3'b100;
    tick(); tick(); tick();
    w_inc_valid = 3'b000;
    w_rd_ch = 2'd3; w_rd_req_valid = 1'b1;
    tick();
    w_rd_req_valid = 1'b0;
    vectors++; if (w_rsp_valid !== 1'b1 || w_rsp_err !== 1'b1 || w_rsp_data !== 4'd0) begin miscompares++; $display("FAIL oor_rsp: got valid %b err %b data %0d want 1 1 0", w_rsp_valid, w_rsp_err, w_rsp_data); end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (w_rsp_valid !== 1'b1 || w_rsp_err !== 1'b1 || w_rsp_data !== 4'd0 || w_rd_req_ready !== 1'b0) begin
        miscompares++; $display("FAIL oor_hold_%0d: got valid %b err %b data %0d req_ready %b want 1 1 0 0", k, w_rsp_valid, w_rsp_err, w_rsp_data, w_rd_req_ready);
      end
    end
    w_rsp_ready = 1'b1;
    tick();
    w_rsp_ready = 1'b0;
    vectors++; if (w_flag !== 3'b100) begin miscompares++; $display("FAIL oor_no_side_effect: got flag %b want 100", w_flag); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic g;
    s_inc_valid = 4'b0010;
    tick(); tick();
    s_inc_valid = 4'b0000;
    s_rd_ch = 2'd1; s_rd_req_valid = 1'b1; s_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (s_rsp_valid !== (k % 2 == 0) || s_rd_req_ready !== (k % 2 == 1) || (s_rsp_valid && s_rsp_data !== 8'd2)) begin
        miscompares++; $display("FAIL b2b_%0d: got valid %b ready %b data %0d want valid %b data 2", k, s_rsp_valid, s_rd_req_ready, s_rsp_data, (k % 2 == 0));
      end
    end
    s_rd_req_valid = 1'b0; s_rsp_ready = 1'b0;
    s_inc_valid = 4'b0010; s_rd_req_valid = 1'b1;
    tick();
    s_inc_valid = 4'b0000; s_rd_req_valid = 1'b0;
    vectors++; if (s_rsp_valid !== 1'b1 || s_rsp_data !== 8'd2) begin miscompares++; $display("FAIL rdinc_pre_value: got %0d (valid %b) want 2", s_rsp_data, s_rsp_valid); end
    s_rsp_ready = 1'b1;
    tick();
    s_rsp_ready = 1'b0;
    s_read(2'd1, d, g);
    vectors++; if (!g || d !== 8'd3) begin miscompares++; $display("FAIL rdinc_post_value: got %0d (rsp %b) want 3", d, g); end
  endtask

  task automatic test_snapshot();
    logic [7:0] d; logic g;
    logic [7:0] exp_snap;
    exp_snap = SNAP_EN ? 8'd3 : 8'd5;
    s_inc_valid = 4'b1000;
    tick(); tick(); tick();
    s_inc_valid = 4'b0000; s_snap = 1'b1;
    tick();
    s_snap = 1'b0; s_inc_valid = 4'b1000;
    tick(); tick();
    s_inc_valid = 4'b0000;
    s_read(2'd3, d, g);
    vectors++; if (!g || d !== exp_snap) begin miscompares++; $display("FAIL snap_read: got %0d (rsp %b) want %0d", d, g, exp_snap); end
    s_snap = 1'b1; s_rd_ch = 2'd3; s_rd_req_valid = 1'b1;
    tick();
    s_snap = 1'b0; s_rd_req_valid = 1'b0;
    vectors++; if (s_rsp_valid !== 1'b1 || s_rsp_data !== exp_snap) begin miscompares++; $display("FAIL snap_coincident: got %0d (valid %b) want %0d", s_rsp_data, s_rsp_valid, exp_snap); end
    s_rsp_ready = 1'b1;
    tick();
    s_rsp_ready = 1'b0;
    s_read(2'd3, d, g);
    vectors++; if (!g || d !== 8'd5) begin miscompares++; $display("FAIL snap_after_update: got %0d (rsp %b) want 5", d, g); end
  endtask

  task automatic test_reset_mid_response();
    w_rd_ch = 2'd2; w_rd_req_valid = 1'b1;
    tick();
    w_rd_req_valid = 1'b0;
    vectors++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 4'd2) begin miscompares++; $display("FAIL mid_rsp_before: got %0d (valid %b) want 2", w_rsp_data, w_rsp_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if (w_rsp_valid !== 1'b0 || w_rd_req_ready !== 1'b1 || w_rsp_data !== 4'd0) begin
      miscompares++; $display("FAIL mid_rsp_reset: got valid %b ready %b data %0d want 0 1 0", w_rsp_valid, w_rd_req_ready, w_rsp_data);
    end
    vectors++; if (w_flag !== 3'b000) begin miscompares++; $display("FAIL mid_rsp_flag: got %b want 000", w_flag); end
    tick();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_clr_priority();
    test_flag_vs_read_clear();
    test_out_of_range();
    test_back_to_back();
    test_snapshot();
    test_reset_mid_response();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
